// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one add/sub/and/or ALU between NREQ valid/ready requesters.
// Optional result flags (resp_zero, resp_carry) are enabled with `define ALU_SHARE_FLAGS_EN.
module alu_share_arbiter #(
  parameter int DW   = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [DW*NREQ-1:0]   req_a,
  input  logic [DW*NREQ-1:0]   req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
`ifdef ALU_SHARE_FLAGS_EN
  output logic                 resp_zero,
  output logic                 resp_carry,
`endif
  output logic [IDW-1:0]       resp_id,
  output logic [DW-1:0]        resp_y
);

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ-1);

  logic [1:0]    op_arr [NREQ];
  logic [DW-1:0] a_arr  [NREQ];
  logic [DW-1:0] b_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_op[2*gi +: 2];
    assign a_arr[gi]  = req_a[DW*gi +: DW];
    assign b_arr[gi]  = req_b[DW*gi +: DW];
  end

  logic [IDW-1:0] rr_ptr, win, nxt_ptr;
  logic [IDW:0]   idx;
  logic           found, can_accept, grant;

  // Scan upward from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  assign can_accept = !resp_valid || resp_ready;
  assign grant      = found && can_accept && !rst;
  assign nxt_ptr    = (win == LAST) ? '0 : win + 1'b1;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  logic [1:0]    w_op;
  logic [DW-1:0] w_a, w_b, b_eff, alu_y;
  assign w_op  = op_arr[win];
  assign w_a   = a_arr[win];
  assign w_b   = b_arr[win];
  assign b_eff = w_op[0] ? ~w_b : w_b;

`ifdef ALU_SHARE_FLAGS_EN
  logic [DW:0] sum;
  logic        alu_c;
  assign sum   = {1'b0, w_a} + {1'b0, b_eff} + {{DW{1'b0}}, w_op[0]};
  assign alu_c = w_op[1] ? 1'b0 : sum[DW];
`else
  logic [DW-1:0] sum;
  assign sum = w_a + b_eff + {{(DW-1){1'b0}}, w_op[0]};
`endif

  always_comb begin
    case (w_op)
      2'b10:   alu_y = w_a & w_b;
      2'b11:   alu_y = w_a | w_b;
      default: alu_y = sum[DW-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_y     <= '0;
      rr_ptr     <= '0;
`ifdef ALU_SHARE_FLAGS_EN
      resp_zero  <= 1'b0;
      resp_carry <= 1'b0;
`endif
    end else if (grant) begin
      resp_valid <= 1'b1;
      resp_id    <= win;
      resp_y     <= alu_y;
      rr_ptr     <= nxt_ptr;
`ifdef ALU_SHARE_FLAGS_EN
      resp_zero  <= (alu_y == '0);
      resp_carry <= alu_c;
`endif
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, directed corner sequences,
// then randomized traffic against an arithmetic reference model.
module tb_alu_share_arbiter;
  localparam int DW = 32, NREQ = 4, IDW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [DW*NREQ-1:0]  req_a, req_b;
  logic                resp_valid, resp_ready;
  logic [IDW-1:0]      resp_id;
  logic [DW-1:0]       resp_y;
`ifdef ALU_SHARE_FLAGS_EN
  logic                resp_zero, resp_carry;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
`ifdef ALU_SHARE_FLAGS_EN
    .resp_zero(resp_zero), .resp_carry(resp_carry),
`endif
    .resp_id(resp_id), .resp_y(resp_y)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op = {NREQ{op}};
    req_a  = {NREQ{a}};
    req_b  = {NREQ{b}};
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [3:0]  exp_ready;
    logic [31:0] exp_y;
    logic [1:0]  exp_id;
    logic        exp_c, exp_z;
  } vec_t;

  vec_t vt [7];

  // Reference model state
  logic        m_valid;
  logic [31:0] m_y;
  int          m_id, m_rr;
  logic        m_c, m_z;
  logic        pend [NREQ];
  logic [1:0]  p_op [NREQ];
  logic [31:0] p_a  [NREQ], p_b [NREQ];

  function automatic logic [31:0] ref_y(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic ref_c(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] t;
    t = {1'b0, a} + {1'b0, b};
    case (op)
      2'd0: return t[32];
      2'd1: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    vt[0] = '{4'b0001, 2'd0, 32'd5, 32'd7, 4'b0001, 32'd12, 2'd0, 1'b0, 1'b0};
    vt[1] = '{4'b0100, 2'd1, 32'd3, 32'd5, 4'b0100, 32'hFFFFFFFE, 2'd2, 1'b0, 1'b0};
    vt[2] = '{4'b1000, 2'd2, 32'hF0F000FF, 32'h0FF00F0F, 4'b1000, 32'h00F0000F, 2'd3, 1'b0, 1'b0};
    vt[3] = '{4'b1000, 2'd3, 32'hF0F000FF, 32'h0FF00F0F, 4'b1000, 32'hFFF00FFF, 2'd3, 1'b0, 1'b0};
    vt[4] = '{4'b1010, 2'd0, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'd0, 2'd1, 1'b1, 1'b1};
    vt[5] = '{4'b1000, 2'd0, 32'hFFFFFFFF, 32'd1, 4'b1000, 32'd0, 2'd3, 1'b1, 1'b1};
    vt[6] = '{4'b0001, 2'd1, 32'd7, 32'd7, 4'b0001, 32'd0, 2'd0, 1'b1, 1'b1};

    // Reset: outputs cleared, no grants while rst is high
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0; set_all(2'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    req_valid = 4'hF;
    #1 chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_y", resp_y, 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
`ifdef ALU_SHARE_FLAGS_EN
    chk("rst_zero", 32'(resp_zero), 32'd0);
    chk("rst_carry", 32'(resp_carry), 32'd0);
`endif
    rst = 1'b0; req_valid = '0;
    tick();

    // Vector table, back-to-back with resp_ready=1
    for (int i = 0; i < 7; i++) begin
      req_valid = vt[i].valid; set_all(vt[i].op, vt[i].a, vt[i].b); resp_ready = 1'b1;
      #1 chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vt[i].exp_ready));
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("vec%0d_y", i), resp_y, vt[i].exp_y);
      chk($sformatf("vec%0d_id", i), 32'(resp_id), 32'(vt[i].exp_id));
`ifdef ALU_SHARE_FLAGS_EN
      chk($sformatf("vec%0d_carry", i), 32'(resp_carry), 32'(vt[i].exp_c));
      chk($sformatf("vec%0d_zero", i), 32'(resp_zero), 32'(vt[i].exp_z));
`endif
    end
    req_valid = '0;
    tick();
    chk("consume_valid", 32'(resp_valid), 32'd0);
    chk("consume_hold_id", 32'(resp_id), 32'd0);

    // Round-robin with all requesters continuously valid
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'hF; set_all(2'd0, 32'd1, 32'd2); resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'd1 << (k % 4));
      tick();
      chk($sformatf("rr%0d_id", k), 32'(resp_id), 32'(k % 4));
    end

    // Backpressure: req1 blocked while result is held
    rst = 1'b1; req_valid = '0; tick(); rst = 1'b0;
    req_valid = 4'b0001; set_all(2'd0, 32'd5, 32'd7);
    tick();
    req_valid = 4'b0010; set_all(2'd1, 32'd100, 32'd1); resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("bp%0d_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d_y", k), resp_y, 32'd12);
      chk($sformatf("bp%0d_id", k), 32'(resp_id), 32'd0);
    end
    resp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("bp_release_y", resp_y, 32'd99);
    chk("bp_release_id", 32'(resp_id), 32'd1);

    // Reset mid-stream with rr_ptr non-zero: req0 must beat req3 afterwards
    resp_ready = 1'b0; req_valid = 4'b1001; rst = 1'b1;
    #1 chk("mrst_ready", 32'(req_ready), 32'd0);
    tick();
    chk("mrst_valid", 32'(resp_valid), 32'd0);
    chk("mrst_y", resp_y, 32'd0);
    rst = 1'b0;
    #1 chk("mrst_after_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("mrst_after_valid", 32'(resp_valid), 32'd1);
    chk("mrst_after_id", 32'(resp_id), 32'd0);

    // Randomized traffic against the reference model
    req_valid = '0; rst = 1'b1; tick(); rst = 1'b0;
    m_valid = 1'b0; m_y = '0; m_id = 0; m_rr = 0; m_c = 1'b0; m_z = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; p_op[i] = '0; p_a[i] = '0; p_b[i] = '0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int g;
      logic [3:0] exp_rdy;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          p_op[i] = 2'($urandom);
          p_a[i]  = ($urandom % 2) ? $urandom : 32'($urandom % 16);
          p_b[i]  = ($urandom % 2) ? $urandom : 32'($urandom % 16);
        end
        req_valid[i]        = pend[i];
        req_op[2*i +: 2]    = p_op[i];
        req_a[32*i +: 32]   = p_a[i];
        req_b[32*i +: 32]   = p_b[i];
      end
      resp_ready = ($urandom % 4) != 0;
      g = -1;
      if (!m_valid || resp_ready)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && pend[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
      #1 chk("rand_ready", 32'(req_ready), 32'(exp_rdy));
      tick();
      if (g >= 0) begin
        m_valid = 1'b1;
        m_y  = ref_y(p_op[g], p_a[g], p_b[g]);
        m_c  = ref_c(p_op[g], p_a[g], p_b[g]);
        m_z  = (m_y == 0);
        m_id = g;
        m_rr = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end else if (m_valid && resp_ready) begin
        m_valid = 1'b0;
      end
      chk("rand_valid", 32'(resp_valid), 32'(m_valid));
      chk("rand_y", resp_y, m_y);
      chk("rand_id", 32'(resp_id), 32'(m_id));
`ifdef ALU_SHARE_FLAGS_EN
      chk("rand_carry", 32'(resp_carry), 32'(m_c));
      chk("rand_zero", 32'(resp_zero), 32'(m_z));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
